// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared types and constants for the frame capture/dump block.
// FRAME_DUMP_HEADER_EN adds the HDR state and enables the header byte helper.
package frame_dump_pkg;

    localparam logic [7:0] SYNC0   = 8'hA5;
    localparam logic [7:0] SYNC1   = 8'h5A;
    localparam int         HDR_LEN = 6;

`ifdef FRAME_DUMP_HEADER_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FS,
        S_CAPTURE,
        S_HDR,
        S_DUMP
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FS,
        S_CAPTURE,
        S_DUMP
    } state_e;
`endif

    // Header byte 'idx' of the dump preamble: sync pair, pixel count (LE), BPP, overflow flag.
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [15:0] cnt,
                                            input logic [7:0]  bpp,
                                            input logic        ovf);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC0;
            3'd1:    b = SYNC1;
            3'd2:    b = cnt[7:0];
            3'd3:    b = cnt[15:8];
            3'd4:    b = bpp;
            3'd5:    b = {7'b0, ovf};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fd_ram.sv
// fd_ram: simple dual-port frame store, one write port and one registered
// read port, written so synthesis maps it onto block RAM.
module fd_ram #(
    parameter int DEPTH = 2,
    parameter int W     = 16,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/frame_capture_dump.sv
// frame_capture_dump: on arm, captures the next CSI frame into fd_ram, then
// streams it out LSB-first per pixel over a valid/ready byte link.
// Macro FRAME_DUMP_HEADER_EN: prepend a 6-byte header (HDR state) to each dump.
module frame_capture_dump
    import frame_dump_pkg::*;
#(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int PIX_W   = 16    // multiple of 8 in 8..32
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               arm,
    input  logic                               frame_start,
    input  logic                               frame_end,
    input  logic [PIX_W-1:0]                   pix_data,
    input  logic                               pix_valid,
    output logic [7:0]                         tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [$clog2(H_PIX*V_LINES+1)-1:0] pix_count
);

    localparam int            DEPTH   = H_PIX * V_LINES;
    localparam int            BPP     = PIX_W / 8;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]    LAST_B  = 2'(BPP - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    wr_addr_q, wr_addr_d;
    logic [CW-1:0]    rd_addr_q, rd_addr_d;
    logic [CW-1:0]    pix_count_q, pix_count_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             rd_pend_q, rd_pend_d;     // read issued last cycle, data on ram_rdata now
    logic [PIX_W-1:0] ow_q, ow_d;               // pixel currently being sent
    logic             ow_v_q, ow_v_d;
    logic [PIX_W-1:0] nx_q, nx_d;               // prefetched next pixel
    logic             nx_v_q, nx_v_d;
    logic [1:0]       bsel_q, bsel_d;           // byte lane of ow_q on tx_data
`ifdef FRAME_DUMP_HEADER_EN
    logic [2:0]       hdr_idx_q, hdr_idx_d;
`endif

    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [PIX_W-1:0] ram_rdata;
    logic [CW-1:0]    base;
    logic [1:0]       occ;
    logic             pop;
    logic [PIX_W-1:0] ow_sh;

    fd_ram #(.DEPTH(DEPTH), .W(PIX_W), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (pix_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign ow_sh = ow_q >> {bsel_q, 3'b000};
`ifdef FRAME_DUMP_HEADER_EN
    assign tx_valid = (state_q == S_HDR) || ((state_q == S_DUMP) && ow_v_q);
    assign tx_data  = (state_q == S_HDR) ?
                      hdr_byte(hdr_idx_q, 16'(pix_count_q), 8'(BPP), overflow_q) : ow_sh[7:0];
`else
    assign tx_valid = (state_q == S_DUMP) && ow_v_q;
    assign tx_data  = ow_sh[7:0];
`endif
    // Last byte of the current pixel leaves this cycle.
    assign pop       = (state_q == S_DUMP) && ow_v_q && tx_ready && (bsel_q == LAST_B);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign pix_count = pix_count_q;

    // Next-state: capture sequencing, prefetching readout and header walk.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        pix_count_d = pix_count_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        rd_pend_d   = 1'b0;
        ow_d        = ow_q;
        ow_v_d      = ow_v_q;
        nx_d        = nx_q;
        nx_v_d      = nx_v_q;
        bsel_d      = bsel_q;
`ifdef FRAME_DUMP_HEADER_EN
        hdr_idx_d   = hdr_idx_q;
`endif
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_re      = 1'b0;
        ram_raddr   = rd_addr_q[AW-1:0];
        base        = wr_addr_q;
        occ         = '0;

        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_WAIT_FS;
            end
            S_WAIT_FS: begin
                if (frame_start) begin
                    state_d     = S_CAPTURE;
                    wr_addr_d   = '0;
                    pix_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                // A fresh frame_start means the previous frame_end was lost.
                base      = frame_start ? '0 : wr_addr_q;
                wr_addr_d = base;
                if (pix_valid) begin
                    if (base < DEPTH_C) begin
                        ram_we    = 1'b1;
                        ram_waddr = base[AW-1:0];
                        wr_addr_d = base + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (frame_end) begin
                    pix_count_d = wr_addr_d;
                    rd_addr_d   = '0;
                    ow_v_d      = 1'b0;
                    nx_v_d      = 1'b0;
                    bsel_d      = '0;
`ifdef FRAME_DUMP_HEADER_EN
                    hdr_idx_d   = '0;
                    state_d     = S_HDR;
`else
                    state_d     = S_DUMP;
`endif
                end
            end
`ifdef FRAME_DUMP_HEADER_EN
            S_HDR: begin
                if (tx_ready) begin
                    if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
                        hdr_idx_d = '0;
                        state_d   = S_DUMP;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end
`endif
            S_DUMP: begin
                // Keep at most two pixels in flight (sending, prefetched or in the RAM pipe).
                occ = 2'(ow_v_q) + 2'(nx_v_q) + 2'(rd_pend_q) - 2'(pop);
                if ((rd_addr_q < pix_count_q) && (occ < 2'd2)) begin
                    ram_re    = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    rd_pend_d = 1'b1;
                end
                if (tx_valid && tx_ready) bsel_d = pop ? 2'd0 : bsel_q + 2'd1;
                if (!ow_v_q || pop) begin
                    if (nx_v_q) begin
                        ow_d   = nx_q;
                        ow_v_d = 1'b1;
                        nx_d   = ram_rdata;
                        nx_v_d = rd_pend_q;
                    end else if (rd_pend_q) begin
                        ow_d   = ram_rdata;
                        ow_v_d = 1'b1;
                    end else begin
                        ow_v_d = 1'b0;
                    end
                end else if (rd_pend_q) begin
                    nx_d   = ram_rdata;
                    nx_v_d = 1'b1;
                end
                // Everything read and sent (also covers an empty capture).
                if ((rd_addr_q == pix_count_q) && !nx_v_q && !rd_pend_q && (!ow_v_q || pop)) begin
                    ow_v_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            pix_count_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            ow_q        <= '0;
            ow_v_q      <= 1'b0;
            nx_q        <= '0;
            nx_v_q      <= 1'b0;
            bsel_q      <= '0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            pix_count_q <= pix_count_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            rd_pend_q   <= rd_pend_d;
            ow_q        <= ow_d;
            ow_v_q      <= ow_v_d;
            nx_q        <= nx_d;
            nx_v_q      <= nx_v_d;
            bsel_q      <= bsel_d;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_idx_q   <= hdr_idx_d;
`endif
        end
    end

endmodule
